// File: rtl/blackbox_check_sequencer_pkg.sv
// Shared types for the black-box check sequencer: FSM states and the
// expected-response helper.
package check_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } seq_state_e;

    // Expected DUT output bit for one stimulus bit (inverter or pass-through).
    function automatic logic expected_bit(input logic stim_bit, input logic invert);
        return stim_bit ^ invert;
    endfunction

endpackage

// File: rtl/blackbox_check_sequencer_expect_delay_line.sv
// LATENCY-stage shift register carrying {valid, expected, index} alongside
// the DUT pipeline; LATENCY==0 is a pure pass-through.
module expect_delay_line #(
    parameter int WIDTH   = 8,
    parameter int IDX_W   = 4,
    parameter int LATENCY = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_exp,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_exp,
    output logic [IDX_W-1:0] out_idx
);

    generate
        if (LATENCY == 0) begin : g_bypass
            logic bypass_unused;
            assign bypass_unused = &{1'b0, clock, reset};

            assign out_valid = in_valid;
            assign out_exp   = in_exp;
            assign out_idx   = in_idx;
        end else begin : g_pipe
            logic [LATENCY-1:0]            valid_q;
            logic [LATENCY-1:0][WIDTH-1:0] exp_q;
            logic [LATENCY-1:0][IDX_W-1:0] idx_q;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    valid_q <= '0;
                    exp_q   <= '0;
                    idx_q   <= '0;
                end else begin
                    valid_q[0] <= in_valid;
                    exp_q[0]   <= in_exp;
                    idx_q[0]   <= in_idx;
                    for (int unsigned i = 1; i < LATENCY; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        exp_q[i]   <= exp_q[i-1];
                        idx_q[i]   <= idx_q[i-1];
                    end
                end
            end

            assign out_valid = valid_q[LATENCY-1];
            assign out_exp   = exp_q[LATENCY-1];
            assign out_idx   = idx_q[LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/blackbox_check_sequencer.sv
// Stimulus/response checker wrapped around a black-box inverter DUT.
// Define SEQ_ASSERT_EN for simulation-only mismatch $fatal and PASS/FAIL prints.
module blackbox_check_sequencer
    import check_seq_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               NUM_VEC = 16,
    parameter int               LATENCY = 1,
    parameter logic [WIDTH-1:0] SEED    = '0,
    parameter int               INVERT  = 1,
    localparam int              CNT_W   = $clog2(NUM_VEC + 1),
    localparam int              IDX_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] dut_in,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic             fail_valid,
    output logic [IDX_W-1:0] fail_index,
    output logic             finish
);

    localparam logic             INV_BIT  = (INVERT != 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] ERR_MAX  = CNT_W'(NUM_VEC);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] stim_q;
    logic [CNT_W-1:0] err_q;
    logic             fail_valid_q;
    logic [IDX_W-1:0] fail_index_q;
    logic             finish_q;

    logic [WIDTH-1:0] issue_exp;
    logic             issue_valid;
    logic             chk_valid;
    logic [WIDTH-1:0] chk_exp;
    logic [IDX_W-1:0] chk_idx;
    logic             mismatch;
    logic             last_check;
    logic             start_ok;

    always_comb begin
        issue_exp = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            issue_exp[i] = expected_bit(stim_q[i], INV_BIT);
        end
    end

    assign issue_valid = (state_q == RUN);

    expect_delay_line #(
        .WIDTH   (WIDTH),
        .IDX_W   (IDX_W),
        .LATENCY (LATENCY)
    ) u_delay (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (issue_valid),
        .in_exp    (issue_exp),
        .in_idx    (idx_q),
        .out_valid (chk_valid),
        .out_exp   (chk_exp),
        .out_idx   (chk_idx)
    );

    assign mismatch   = chk_valid && (dut_out != chk_exp);
    assign last_check = chk_valid && (chk_idx == LAST_IDX);
    assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = RUN;
            RUN:   if (idx_q == LAST_IDX) state_d = (LATENCY == 0) ? DONE : DRAIN;
            DRAIN: if (last_check) state_d = DONE;
            DONE:  if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            stim_q       <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_index_q <= '0;
            finish_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            finish_q <= (state_d == DONE) && (state_q != DONE);
            if (start_ok) begin
                idx_q        <= '0;
                stim_q       <= SEED;
                err_q        <= '0;
                fail_valid_q <= 1'b0;
                fail_index_q <= '0;
            end else begin
                // Vector 0 was loaded on the start edge; later vectors step by one.
                if ((state_q == RUN) && (idx_q != LAST_IDX)) begin
                    idx_q  <= idx_q + IDX_W'(1);
                    stim_q <= stim_q + WIDTH'(1);
                end
                if (mismatch) begin
                    if (err_q != ERR_MAX) err_q <= err_q + CNT_W'(1);
                    if (!fail_valid_q) begin
                        fail_valid_q <= 1'b1;
                        fail_index_q <= chk_idx;
                    end
                end
            end
        end
    end

    assign dut_in     = stim_q;
    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign done       = (state_q == DONE);
    assign pass       = (state_q == DONE) && (err_q == '0);
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign fail_index = fail_index_q;
    assign finish     = finish_q;

`ifdef SEQ_ASSERT_EN
`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (reset && mismatch) begin
            $display("blackbox_check_sequencer mismatch idx=%d exp=%h got=%h",
                     chk_idx, chk_exp, dut_out);
            $fatal(1);
        end
        if (reset && finish_q) begin
            $display("blackbox_check_sequencer %s err_count=%0d",
                     (err_q == '0) ? "PASS" : "FAIL", err_q);
        end
    end
`endif
`endif

endmodule
